// File: rtl/exu_issue_ctrl_pkg.sv
// Shared opcode/func7 constants, controller state encoding and the M-extension decode helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exu_issue_ctrl_pkg;

    localparam logic [6:0] INST_TYPE_R   = 7'b0110011;
    localparam logic [6:0] INST_TYPE_R32 = 7'b0111011;
    localparam logic [6:0] FUNC7_MEXT    = 7'b0000001;

    typedef enum logic {
        EXC_IDLE    = 1'b0,
        EXC_MC_WAIT = 1'b1
    } exc_state_e;

    // Multi-cycle ops are exactly the RV64M encodings of OP and OP-32.
    function automatic logic is_mext_op(input logic [6:0] op, input logic [6:0] f7);
        return ((op == INST_TYPE_R) || (op == INST_TYPE_R32)) && (f7 == FUNC7_MEXT);
    endfunction

endpackage

// File: rtl/exu_wdog.sv
// Loadable up-counter with clear/enable; tc_o flags the TIMEOUT-1 terminal count.
// Latency: tc_o is combinational from the count register; updates on the rising edge.
// Backpressure: none; clear has priority over load, load over enable.
module exu_wdog #(
    parameter int TIMEOUT = 64,
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          tc_o
);

    localparam logic [CW-1:0] TC_VAL  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/exu_issue_ctrl.sv
// Issue/commit sequencer: ALU results go straight to the RF port, MDU ops park the front end.
// Latency: ALU ops retire in the accept cycle; MDU ops retire on mdu_done or watchdog abort.
// Backpressure: id_ready is low for every MC_WAIT cycle, high otherwise.
module exu_issue_ctrl
    import exu_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [6:0]            opcode,
    input  logic [6:0]            func7,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    input  logic                  alu_rd_wen,
    input  logic [ADDR_WIDTH-1:0] alu_rd_addr,
    input  logic [DATA_WIDTH-1:0] alu_rd_data,
    output logic                  mdu_start,
    input  logic                  mdu_done,
    input  logic [DATA_WIDTH-1:0] mdu_rd_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit,
    output logic                  wdog_err,
    output logic [CNT_WIDTH-1:0]  retired_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    exc_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  wdog_err_q, wdog_err_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;

    logic is_mc;
    logic in_wait;
    logic mc_accept;
    logic mc_abort;
    logic wdog_en;
    logic wdog_tc;

    assign is_mc     = is_mext_op(opcode, func7);
    assign in_wait   = (state_q == EXC_MC_WAIT);
    assign mc_accept = !in_wait && id_valid && is_mc;
    // mdu_done wins over a coincident terminal count.
    assign mc_abort  = in_wait && !mdu_done && wdog_tc;
    assign wdog_en   = in_wait && !mdu_done && !wdog_tc;

    exu_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (mc_accept),
        .en_i       (wdog_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tc_o       (wdog_tc)
    );

    always_comb begin
        id_ready  = !in_wait;
        mdu_start = mc_accept;
        rf_wen    = 1'b0;
        rf_waddr  = alu_rd_addr;
        rf_wdata  = alu_rd_data;
        commit    = 1'b0;
        if (in_wait) begin
            if (mdu_done) begin
                rf_wen   = (rd_q != '0);
                rf_waddr = rd_q;
                rf_wdata = mdu_rd_data;
                commit   = 1'b1;
            end else if (wdog_tc) begin
                commit = 1'b1;
            end
        end else if (id_valid && !is_mc) begin
            // EXU already gates x0 writes, so its enable passes through untouched.
            rf_wen = alu_rd_wen;
            commit = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wdog_err_d = wdog_err_q | mc_abort;
        retired_d  = commit  ? (retired_q + CNT_ONE) : retired_q;
        stall_d    = in_wait ? (stall_q + CNT_ONE)   : stall_q;
        case (state_q)
            EXC_IDLE: begin
                if (mc_accept) begin
                    rd_d    = rd_addr_in;
                    state_d = EXC_MC_WAIT;
                end
            end
            EXC_MC_WAIT: begin
                if (mdu_done || wdog_tc) begin
                    state_d = EXC_IDLE;
                end
            end
            default: state_d = EXC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EXC_IDLE;
            rd_q       <= '0;
            wdog_err_q <= 1'b0;
            retired_q  <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wdog_err_q <= wdog_err_d;
            retired_q  <= retired_d;
            stall_q    <= stall_d;
        end
    end

    assign wdog_err    = wdog_err_q;
    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Scoreboard bench for exu_issue_ctrl: driver pushes expected commits/starts, monitor compares.
module tb_exu_issue_ctrl;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int TO = 8;
    localparam int CW = 64;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_R32 = 7'b0111011;
    localparam logic [6:0] F7_M   = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic          id_ready;
    logic [6:0]    opcode = '0;
    logic [6:0]    func7 = '0;
    logic [AW-1:0] rd_addr_in = '0;
    logic          alu_rd_wen = 1'b0;
    logic [AW-1:0] alu_rd_addr = '0;
    logic [DW-1:0] alu_rd_data = '0;
    logic          mdu_start;
    logic          mdu_done = 1'b0;
    logic [DW-1:0] mdu_rd_data = '0;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          commit;
    logic          wdog_err;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] stall_cnt;

    exu_issue_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .opcode      (opcode),
        .func7       (func7),
        .rd_addr_in  (rd_addr_in),
        .alu_rd_wen  (alu_rd_wen),
        .alu_rd_addr (alu_rd_addr),
        .alu_rd_data (alu_rd_data),
        .mdu_start   (mdu_start),
        .mdu_done    (mdu_done),
        .mdu_rd_data (mdu_rd_data),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .commit      (commit),
        .wdog_err    (wdog_err),
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
        logic [CW-1:0] ret;
        logic [CW-1:0] stall;
    } exp_t;

    exp_t cq[$];
    int   sq[$];
    exp_t me;
    bit   ec;
    bit   es;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   tb_busy = 1'b0;
    logic [CW-1:0] m_ret = '0;
    logic [CW-1:0] m_stall = '0;
    logic          m_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Expected values of the commit cycle: counters and error flag are their pre-commit values.
    function automatic void push_commit(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.cyc = cyc; e.wen = wen; e.addr = a; e.data = d;
        e.err = m_err; e.ret = m_ret; e.stall = m_stall;
        cq.push_back(e);
        m_ret++;
    endfunction

    always @(negedge clk) begin
        ec = (cq.size() > 0) && (cq[0].cyc == cyc);
        chk("commit", 64'(commit), 64'(ec));
        if (ec) begin
            me = cq.pop_front();
            chk("rf_wen", 64'(rf_wen), 64'(me.wen));
            if (me.wen) begin
                chk("rf_waddr", 64'(rf_waddr), 64'(me.addr));
                chk("rf_wdata", rf_wdata, me.data);
            end
            chk("wdog_err", 64'(wdog_err), 64'(me.err));
            chk("retired_cnt", retired_cnt, me.ret);
            chk("stall_cnt", stall_cnt, me.stall);
        end else begin
            chk("rf_wen_no_commit", 64'(rf_wen), 64'(0));
        end
        es = (sq.size() > 0) && (sq[0] == cyc);
        chk("mdu_start", 64'(mdu_start), 64'(es));
        if (es) void'(sq.pop_front());
        chk("id_ready", 64'(id_ready), 64'(!tb_busy));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            id_valid    = 1'b0;
            opcode      = 7'($urandom);
            func7       = 7'($urandom);
            alu_rd_wen  = 1'($urandom);
            alu_rd_addr = AW'($urandom);
            mdu_done    = spur ? 1'($urandom) : 1'b0;
            mdu_rd_data = DW'({$urandom, $urandom});
            step();
        end
        mdu_done = 1'b0;
    endtask

    task automatic alu_op(input logic [6:0] op, input logic [6:0] f7, input logic wen,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input bit spur);
        id_valid    = 1'b1;
        opcode      = op;
        func7       = f7;
        rd_addr_in  = AW'($urandom);
        alu_rd_wen  = wen;
        alu_rd_addr = a;
        alu_rd_data = d;
        mdu_done    = spur;
        mdu_rd_data = DW'({$urandom, $urandom});
        push_commit(wen, a, d);
        step();
        id_valid = 1'b0;
        mdu_done = 1'b0;
    endtask

    task automatic rand_alu();
        logic [6:0] op;
        logic [6:0] f7;
        op = 7'($urandom);
        f7 = ($urandom_range(0, 3) == 0) ? F7_M : 7'($urandom);
        if ($urandom_range(0, 2) == 0) op = $urandom_range(0, 1) ? OP_R : OP_R32;
        if ((op == OP_R || op == OP_R32) && f7 == F7_M) f7 = 7'b0100000;
        alu_op(op, f7, 1'($urandom), AW'($urandom), DW'({$urandom, $urandom}), 1'($urandom));
    endtask

    // lat > TO means the MDU never answers and the watchdog must abort in wait cycle TO.
    task automatic mc_op(input logic [AW-1:0] rd, input int lat, input bit spur, input logic [DW-1:0] d);
        id_valid    = 1'b1;
        opcode      = $urandom_range(0, 1) ? OP_R : OP_R32;
        func7       = F7_M;
        rd_addr_in  = rd;
        alu_rd_wen  = 1'($urandom);
        alu_rd_addr = AW'($urandom);
        mdu_done    = spur;
        mdu_rd_data = DW'({$urandom, $urandom});
        sq.push_back(cyc);
        step();
        tb_busy = 1'b1;
        for (int c = 1; c <= TO; c++) begin
            id_valid    = 1'($urandom);
            opcode      = 7'($urandom);
            func7       = 7'($urandom);
            rd_addr_in  = AW'($urandom);
            alu_rd_wen  = 1'($urandom);
            alu_rd_addr = AW'($urandom);
            alu_rd_data = DW'({$urandom, $urandom});
            mdu_rd_data = d;
            mdu_done    = (c == lat);
            if (c == lat) push_commit(rd != '0, rd, d);
            else if (c == TO) push_commit(1'b0, '0, '0);
            m_stall++;
            step();
            if (c == lat || c == TO) begin
                if (c != lat) m_err = 1'b1;
                break;
            end
        end
        tb_busy  = 1'b0;
        id_valid = 1'b0;
        mdu_done = 1'b0;
    endtask

    task automatic reset_mid_wait();
        id_valid   = 1'b1;
        opcode     = OP_R;
        func7      = F7_M;
        rd_addr_in = 5'd3;
        mdu_done   = 1'b0;
        sq.push_back(cyc);
        step();
        tb_busy  = 1'b1;
        id_valid = 1'b0;
        m_stall++;
        step();
        #1 rst_n = 1'b0;
        tb_busy = 1'b0;
        m_ret   = '0;
        m_stall = '0;
        m_err   = 1'b0;
        #1;
        chk("rst_id_ready", 64'(id_ready), 64'(1));
        chk("rst_retired", retired_cnt, '0);
        chk("rst_stall", stall_cnt, '0);
        chk("rst_wdog_err", 64'(wdog_err), 64'(0));
        chk("rst_commit", 64'(commit), 64'(0));
        #1 rst_n = 1'b1;
        step();
        mdu_done    = 1'b1;
        mdu_rd_data = 64'hDEAD_BEEF;
        step();
        step();
        mdu_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_id_ready", 64'(id_ready), 64'(1));
        chk("reset_mdu_start", 64'(mdu_start), 64'(0));
        chk("reset_rf_wen", 64'(rf_wen), 64'(0));
        chk("reset_commit", 64'(commit), 64'(0));
        chk("reset_wdog_err", 64'(wdog_err), 64'(0));
        chk("reset_retired", retired_cnt, '0);
        chk("reset_stall", stall_cnt, '0);
        #6 rst_n = 1'b1;
        step();

        alu_op(7'b0010011, 7'b0000000, 1'b1, 5'd5, 64'h2A, 1'b0);
        idle(1, 1'b0);
        chk("addi_retired", retired_cnt, 64'd1);
        mc_op(5'd7, 4, 1'b0, 64'h1234);
        chk("mul_stall", stall_cnt, 64'd4);
        mc_op(5'd0, 2, 1'b0, 64'h55);
        mc_op(5'd9, TO + 1, 1'b0, 64'h77);
        chk("abort_err_set", 64'(wdog_err), 64'(1));
        alu_op(7'b0110011, 7'b0000000, 1'b1, 5'd1, 64'h11, 1'b0);
        alu_op(7'b0010011, F7_M, 1'b1, 5'd2, 64'h22, 1'b0);
        idle(3, 1'b1);
        mc_op(5'd12, 1, 1'b1, 64'hABCD);
        mc_op(5'd13, TO, 1'b0, 64'h9999);
        reset_mid_wait();
        chk("post_reset_retired", retired_cnt, '0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1:       idle($urandom_range(1, 3), 1'b1);
                2, 3, 4, 5: rand_alu();
                default:    mc_op(($urandom_range(0, 4) == 0) ? 5'd0 : AW'($urandom),
                                  $urandom_range(1, TO + 2), 1'($urandom), DW'({$urandom, $urandom}));
            endcase
        end

        idle(2, 1'b0);
        chk("final_retired", retired_cnt, m_ret);
        chk("final_stall", stall_cnt, m_stall);
        chk("final_wdog_err", 64'(wdog_err), 64'(m_err));
        chk("commit_queue_drained", 64'(cq.size()), 64'(0));
        chk("start_queue_drained", 64'(sq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
